// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU control decoder.
//   - ALU operation codes (0..14)
//   - B-operand select encodings
//   - MIPS opcode / funct field values
//   - dec_t: decoded field bundle carried through the output/skid stage
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;
  localparam logic [3:0] ALU_NE  = 4'd10;
  localparam logic [3:0] ALU_LTZ = 4'd11;
  localparam logic [3:0] ALU_LEZ = 4'd12;
  localparam logic [3:0] ALU_GTZ = 4'd13;
  localparam logic [3:0] ALU_GEZ = 4'd14;

  localparam logic [1:0] BSEL_RT    = 2'd0;
  localparam logic [1:0] BSEL_SIMM  = 2'd1;
  localparam logic [1:0] BSEL_ZIMM  = 2'd2;
  localparam logic [1:0] BSEL_SHAMT = 2'd3;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h02;

  typedef struct packed {
    logic       illegal;
    logic       reg_write;
    logic       branch_on_zero;
    logic [1:0] b_sel;
    logic       a_sel;
    logic [3:0] alu_control;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  function automatic dec_t dec_legal(input logic [3:0] alu, input logic a_sel,
                                     input logic [1:0] b_sel, input logic boz,
                                     input logic rw);
    dec_t d;
    d.illegal        = 1'b0;
    d.reg_write      = rw;
    d.branch_on_zero = boz;
    d.b_sel          = b_sel;
    d.a_sel          = a_sel;
    d.alu_control    = alu;
    return d;
  endfunction

endpackage

// File: rtl/alu_dec_skid.sv
// alu_dec_skid: output register plus one skid register, valid/ready on both
// sides. in_ready is registered; it drops the cycle after the skid fills and
// returns the cycle after the skid entry moves to the output register.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload
module alu_dec_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    in_fire      = in_valid & in_ready_q;

    if (skid_valid_q) begin
      // in_ready_q is low here, so nothing new can arrive this cycle
      if (out_ready) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/alu_control_decoder.sv
// alu_control_decoder: decodes a MIPS instruction word into ALU control
// fields, buffered through an output+skid stage (alu_dec_skid).
// Build option: define ALU_MULT_EN to decode op 0x1C funct 0x02 (mul);
// otherwise that encoding is illegal.
// Ports:
//   Clk, Rst_n                 clock, async active-low reset
//   In_Valid/In_Ready, Instr   instruction input handshake
//   Out_Valid/Out_Ready        decoded-field output handshake
//   ALUControl, ASel, BSel, BranchOnZero, RegWrite, Illegal  decoded fields
//   IllegalCount               saturating count of accepted illegal instrs
module alu_control_decoder
  import alu_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] Instr,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [3:0]  ALUControl,
  output logic        ASel,
  output logic [1:0]  BSel,
  output logic        BranchOnZero,
  output logic        RegWrite,
  output logic        Illegal,
  output logic [15:0] IllegalCount
);

  logic [5:0]       op, funct;
  logic [4:0]       rt;
  dec_t             dec;
  dec_t             out_dec;
  logic [DEC_W-1:0] out_data;
  logic             in_fire;
  logic [15:0]      ill_cnt_q, ill_cnt_d;
  logic             unused_instr_bits;

  assign op    = Instr[31:26];
  assign rt    = Instr[20:16];
  assign funct = Instr[5:0];
  assign unused_instr_bits = ^{Instr[25:21], Instr[15:6]};

  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    unique case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD: dec = dec_legal(ALU_ADD, 1'b0, BSEL_RT, 1'b0, 1'b1);
          F_SUB: dec = dec_legal(ALU_SUB, 1'b0, BSEL_RT, 1'b0, 1'b1);
          F_AND: dec = dec_legal(ALU_AND, 1'b0, BSEL_RT, 1'b0, 1'b1);
          F_OR:  dec = dec_legal(ALU_OR,  1'b0, BSEL_RT, 1'b0, 1'b1);
          F_NOR: dec = dec_legal(ALU_NOR, 1'b0, BSEL_RT, 1'b0, 1'b1);
          F_XOR: dec = dec_legal(ALU_XOR, 1'b0, BSEL_RT, 1'b0, 1'b1);
          F_SLT: dec = dec_legal(ALU_SLT, 1'b0, BSEL_RT, 1'b0, 1'b1);
          // shifts operate on rt, shamt reaches the ALU via the raw imm16
          F_SLL: dec = dec_legal(ALU_SLL, 1'b1, BSEL_SHAMT, 1'b0, 1'b1);
          F_SRL: dec = dec_legal(ALU_SRL, 1'b1, BSEL_SHAMT, 1'b0, 1'b1);
          default: ;
        endcase
      end
      OP_ADDI: dec = dec_legal(ALU_ADD, 1'b0, BSEL_SIMM, 1'b0, 1'b1);
      OP_SLTI: dec = dec_legal(ALU_SLT, 1'b0, BSEL_SIMM, 1'b0, 1'b1);
      OP_ANDI: dec = dec_legal(ALU_AND, 1'b0, BSEL_ZIMM, 1'b0, 1'b1);
      OP_ORI:  dec = dec_legal(ALU_OR,  1'b0, BSEL_ZIMM, 1'b0, 1'b1);
      OP_XORI: dec = dec_legal(ALU_XOR, 1'b0, BSEL_ZIMM, 1'b0, 1'b1);
      OP_LW:   dec = dec_legal(ALU_ADD, 1'b0, BSEL_SIMM, 1'b0, 1'b1);
      OP_SW:   dec = dec_legal(ALU_ADD, 1'b0, BSEL_SIMM, 1'b0, 1'b0);
      // branch is taken when the ALU result is zero, so each test is the
      // complement of the branch condition
      OP_BEQ:  dec = dec_legal(ALU_SUB, 1'b0, BSEL_RT, 1'b1, 1'b0);
      OP_BNE:  dec = dec_legal(ALU_NE,  1'b0, BSEL_RT, 1'b1, 1'b0);
      OP_BLEZ: dec = dec_legal(ALU_GTZ, 1'b0, BSEL_RT, 1'b1, 1'b0);
      OP_BGTZ: dec = dec_legal(ALU_LEZ, 1'b0, BSEL_RT, 1'b1, 1'b0);
      OP_REGIMM: begin
        if (rt == 5'd0)
          dec = dec_legal(ALU_GEZ, 1'b0, BSEL_RT, 1'b1, 1'b0);
        else if (rt == 5'd1)
          dec = dec_legal(ALU_LTZ, 1'b0, BSEL_RT, 1'b1, 1'b0);
      end
`ifdef ALU_MULT_EN
      OP_SPECIAL2: begin
        if (funct == F_MUL)
          dec = dec_legal(ALU_MUL, 1'b0, BSEL_RT, 1'b0, 1'b1);
      end
`else
`endif
      default: ;
    endcase
  end

  assign in_fire = In_Valid & In_Ready;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (in_fire && dec.illegal && (ill_cnt_q != 16'hFFFF))
      ill_cnt_d = ill_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ill_cnt_q <= '0;
    else        ill_cnt_q <= ill_cnt_d;
  end

  alu_dec_skid #(.WIDTH(DEC_W)) u_skid (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .in_valid  (In_Valid),
    .in_ready  (In_Ready),
    .in_data   (dec),
    .out_valid (Out_Valid),
    .out_ready (Out_Ready),
    .out_data  (out_data)
  );

  assign out_dec      = out_data;
  assign ALUControl   = out_dec.alu_control;
  assign ASel         = out_dec.a_sel;
  assign BSel         = out_dec.b_sel;
  assign BranchOnZero = out_dec.branch_on_zero;
  assign RegWrite     = out_dec.reg_write;
  assign Illegal      = out_dec.illegal;
  assign IllegalCount = ill_cnt_q;

endmodule

// File: tb/tb_alu_control_decoder.sv
// Self-checking bench for alu_control_decoder. Expected decodes come from a
// hand-written table; accepted instructions push their expectation into a
// queue that is popped whenever the DUT hands an output to the consumer.
module tb_alu_control_decoder;

  logic        Clk, Rst_n, In_Valid, In_Ready, Out_Valid, Out_Ready;
  logic [31:0] Instr;
  logic [3:0]  ALUControl;
  logic        ASel, BranchOnZero, RegWrite, Illegal;
  logic [1:0]  BSel;
  logic [15:0] IllegalCount;

  alu_control_decoder dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Instr(Instr), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .ALUControl(ALUControl), .ASel(ASel), .BSel(BSel),
    .BranchOnZero(BranchOnZero), .RegWrite(RegWrite), .Illegal(Illegal),
    .IllegalCount(IllegalCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam int N = 26;
  localparam int I_ADD = 0, I_SLL = 7, I_BNE = 17, I_ILL = 22, I_MUL = 25;

  logic [31:0] t_instr [N];
  logic [9:0]  t_exp   [N];   // {ill, rw, boz, bsel[1:0], asel, alu[3:0]}
  logic [9:0]  sb_q[$];
  logic [15:0] exp_cnt;
  int          n_err, n_checks, cur_idx;
  bit          last_in_fire, rdy_rand;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int i, input logic [31:0] ins, input logic [3:0] ac,
                      input logic as, input logic [1:0] bs, input logic boz,
                      input logic rw, input logic ill);
    t_instr[i] = ins;
    t_exp[i]   = {ill, rw, boz, bs, as, ac};
  endtask

  function automatic logic [9:0] got_dec();
    return {Illegal, RegWrite, BranchOnZero, BSel, ASel, ALUControl};
  endfunction

  task automatic mon();
    logic [9:0] e;
    last_in_fire = 1'b0;
    if (!Rst_n) return;
    if (Out_Valid && Out_Ready) begin
      if (sb_q.size() == 0) check("spurious_out", {31'd0, Out_Valid}, 32'd0);
      else begin
        e = sb_q.pop_front();
        check("dec", {22'd0, got_dec()}, {22'd0, e});
        check("ill_cnt", {16'd0, IllegalCount}, {16'd0, exp_cnt});
      end
    end
    if (In_Valid && In_Ready) begin
      last_in_fire = 1'b1;
      sb_q.push_back(t_exp[cur_idx]);
      if (t_exp[cur_idx][9] && exp_cnt != 16'hFFFF) exp_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    mon();
    @(posedge Clk);
    #1;
    if (rdy_rand) Out_Ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input int idx);
    bit acc;
    acc = 1'b0;
    Instr = t_instr[idx]; cur_idx = idx; In_Valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      tick();
      acc = last_in_fire;
    end
    if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    rdy_rand = 1'b0; Out_Ready = 1'b1;
    for (int n = 0; n < 100 && sb_q.size() != 0; n++) tick();
    tick();
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    n_err = 0; n_checks = 0; exp_cnt = '0; cur_idx = 0;
    rdy_rand = 1'b0; last_in_fire = 1'b0;
    Rst_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1; Instr = '0;

    fill(0,  32'h00221820, 4'd0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    fill(1,  32'h00221822, 4'd1,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    fill(2,  32'h00221824, 4'd3,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    fill(3,  32'h00221825, 4'd4,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    fill(4,  32'h00221827, 4'd5,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    fill(5,  32'h00221826, 4'd6,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    fill(6,  32'h0022182A, 4'd9,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    fill(7,  32'h00011100, 4'd7,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    fill(8,  32'h00011102, 4'd8,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    fill(9,  32'h20220005, 4'd0,  1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    fill(10, 32'h2822FFFF, 4'd9,  1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    fill(11, 32'h302200FF, 4'd3,  1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
    fill(12, 32'h342200FF, 4'd4,  1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
    fill(13, 32'h382200FF, 4'd6,  1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
    fill(14, 32'h8C220004, 4'd0,  1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    fill(15, 32'hAC220004, 4'd0,  1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    fill(16, 32'h10220003, 4'd1,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    fill(17, 32'h1420FFFF, 4'd10, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    fill(18, 32'h18200002, 4'd13, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    fill(19, 32'h1C200002, 4'd12, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    fill(20, 32'h04200002, 4'd14, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    fill(21, 32'h04210002, 4'd11, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    fill(22, 32'h04220002, 4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    fill(23, 32'h00221821, 4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    fill(24, 32'hFC000000, 4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_MULT_EN
    fill(25, 32'h70221002, 4'd2,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
`else
    fill(25, 32'h70221002, 4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
`endif

    // reset state
    #12;
    check("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    check("rst_fields", {22'd0, got_dec()}, 32'd0);
    check("rst_ill_cnt", {16'd0, IllegalCount}, 32'd0);
    @(posedge Clk); #1; Rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, In_Ready}, 32'd1);

    // single accepts from idle: result visible one cycle later
    send(I_ADD);
    check("lat_valid", {31'd0, Out_Valid}, 32'd1);
    check("lat_add", {22'd0, got_dec()}, {22'd0, t_exp[I_ADD]});
    tick();
    send(I_SLL);
    check("sll", {22'd0, got_dec()}, {22'd0, t_exp[I_SLL]});
    tick();
    send(I_BNE);
    check("bne", {22'd0, got_dec()}, {22'd0, t_exp[I_BNE]});
    tick();
    send(I_MUL);
    check("mul", {22'd0, got_dec()}, {22'd0, t_exp[I_MUL]});
    check("mul_cnt", {16'd0, IllegalCount}, {16'd0, exp_cnt});
    drain();

    // every table entry through an always-ready consumer
    for (int i = 0; i < N; i++) send(i);
    drain();

    // stalled consumer: two held, third blocked
    Out_Ready = 1'b0;
    send(I_ADD);
    send(I_SLL);
    check("held_in_ready", {31'd0, In_Ready}, 32'd0);
    Instr = t_instr[I_BNE]; cur_idx = I_BNE; In_Valid = 1'b1;
    tick(); tick();
    check("held_in_ready2", {31'd0, In_Ready}, 32'd0);
    check("held_fields", {22'd0, got_dec()}, {22'd0, t_exp[I_ADD]});
    Out_Ready = 1'b1;
    send(I_BNE);
    drain();

    // random valid/ready traffic
    rdy_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send($urandom_range(0, N - 1));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();

    // reset with the skid full
    Out_Ready = 1'b0;
    send(I_ILL);
    send(I_ADD);
    check("pre_rst_in_ready", {31'd0, In_Ready}, 32'd0);
    check("pre_rst_cnt", {16'd0, IllegalCount}, {16'd0, exp_cnt});
    #2 Rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    check("mid_rst_cnt", {16'd0, IllegalCount}, 32'd0);
    sb_q.delete(); exp_cnt = '0;
    Out_Ready = 1'b1;
    tick(); tick();
    Rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, In_Ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    send(I_BNE);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_control_decoder.md
ALU_CONTROL_DECODER -- requirements
Module: alu_control_decoder

Interface
REQ-001 SHALL have port Clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port Rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port In_Valid, input, 1: Instr is valid.
REQ-004 SHALL have port In_Ready, output, 1: decoder can accept; registered.
REQ-005 SHALL have port Instr, input, 32: MIPS instruction word.
REQ-006 SHALL have port Out_Valid, output, 1: decoded fields are valid.
REQ-007 SHALL have port Out_Ready, input, 1: execute stage consumes.
REQ-008 SHALL have port ALUControl, output, 4: ALU operation code, 0..14.
REQ-009 SHALL have port ASel, output, 1: ALU A operand; 0 = rs, 1 = rt.
REQ-010 SHALL have port BSel, output, 2: ALU B operand; 0 = rt, 1 = sign-extended imm16, 2 = zero-extended imm16, 3 = Instr[15:0] zero-extended (shamt in B[10:6]).
REQ-011 SHALL have port BranchOnZero, output, 1: branch taken when ALU Zero=1.
REQ-012 SHALL have port RegWrite, output, 1: result is written back.
REQ-013 SHALL have port Illegal, output, 1: opcode/funct not supported.
REQ-014 SHALL have port IllegalCount, output, 16: saturating count of illegal instructions accepted.

Function
REQ-015 SHALL use ALU codes: add 0, sub 1, mul 2, and 3, or 4, nor 5, xor 6, sll 7, srl 8, slt 9, ne-test 10, ltz-test 11, lez-test 12, gtz-test 13, gez-test 14.
REQ-016 SHALL decode R-type (op 0x00) funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x26 xor, 0x2A slt (BSel 0, RegWrite 1); 0x00 sll, 0x02 srl (ASel 1, BSel 3, RegWrite 1).
REQ-017 SHALL decode I-type: addi 0x08 add/BSel1; slti 0x0A slt/BSel1; andi 0x0C, ori 0x0D, xori 0x0E with BSel2; lw 0x23 add/BSel1/RegWrite1; sw 0x2B add/BSel1/RegWrite0.
REQ-018 SHALL decode branches with BranchOnZero=1, RegWrite=0: beq 0x04 -> 1; bne 0x05 -> 10; blez 0x06 -> 13; bgtz 0x07 -> 12; op 0x01 rt=0 (bltz) -> 14; op 0x01 rt=1 (bgez) -> 11.
REQ-019 SHALL, for any other encoding, output Illegal=1, ALUControl=0, RegWrite=0, BranchOnZero=0, ASel=0, BSel=0.
REQ-020 SHALL present decoded fields one cycle after acceptance when output stage is empty or draining.
REQ-021 SHALL contain output register plus one skid register; accepted item goes to skid when output is held (Out_Valid=1, Out_Ready=0).
REQ-022 SHALL drive In_Ready=0 the cycle after skid fills; In_Ready=1 the cycle after skid moves to output.
REQ-023 SHALL preserve instruction order; no drop or duplication under any Valid/Ready pattern.
REQ-024 SHALL hold all output fields stable while Out_Valid=1 and Out_Ready=0.
REQ-025 SHALL increment IllegalCount on acceptance of an illegal instruction; saturate at 0xFFFF.

Reset
REQ-026 SHALL on Rst_n=0 immediately clear Out_Valid, skid, IllegalCount, all decoded fields to 0; In_Ready=1 after release.
REQ-027 SHALL discard in-flight items when reset asserts mid-operation.

Configuration
REQ-028 SHALL, with ALU_MULT_EN defined, decode op 0x1C funct 0x02 (mul) as code 2, BSel 0, RegWrite 1.
REQ-029 SHALL, without ALU_MULT_EN, treat op 0x1C as illegal per REQ-019; code 2 never emitted.

Structure
REQ-030 SHALL place ALU code constants, BSel encodings, opcode/funct constants in shared package alu_pkg.
REQ-031 SHALL implement output+skid storage as sub-module alu_dec_skid (parametrised width); decode logic combinational in parent.

Verification
REQ-032 SHALL test 0x00221820 (add) accepted idle -> next cycle Out_Valid=1, ALUControl=0, BSel=0, RegWrite=1.
REQ-033 SHALL test 0x00011100 (sll $2,$1,4) -> ALUControl=7, ASel=1, BSel=3; 0x1420FFFF (bne) -> ALUControl=10, BranchOnZero=1, RegWrite=0.
REQ-034 SHALL test 0x70221002 -> ALUControl=2 with ALU_MULT_EN; Illegal=1, IllegalCount +1 without.
REQ-035 SHALL test Out_Ready=0, three back-to-back instrs -> two held, In_Ready=0 after second; Out_Ready=1 -> all three emitted in order.
REQ-036 SHALL test Rst_n low with skid full -> Out_Valid=0, IllegalCount=0 same cycle; In_Ready=1 after release.
